goertz_coeff_arbiter: RTL

GOERTZ_COEFF_ARBITER -- requirements
Module: goertz_coeff_arbiter

---
 rtl/goertz_coeff_arbiter_if.sv | 39 +++
 rtl/goertz_coeff_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/goertz_coeff_arbiter_if.sv
// Bundle of handshake and data signals around the Goertzel coefficient arbiter.
//   enable, lane0_rq/lane1_rq        : grant permission and level requests from the DSP lanes
//   lane*_sin/lane*_cos, lane*_vld   : registered coefficients per lane and their update pulse
//   fd_rq, fd_ready, fd_sin, fd_cos  : request/acknowledge/data of the shared coefficient feeder
//   run_idx, cycle_done, busy, err   : status
// Modport master is the arbiter side; slave is the lanes/feeder/environment side.
interface goertz_coeff_arbiter_if #(
  parameter int unsigned D_W = 16
);
  logic           enable;
  logic           lane0_rq;
  logic           lane1_rq;
  logic [D_W-1:0] lane0_sin;
  logic [D_W-1:0] lane0_cos;
  logic [D_W-1:0] lane1_sin;
  logic [D_W-1:0] lane1_cos;
  logic           lane0_vld;
  logic           lane1_vld;
  logic           fd_rq;
  logic           fd_ready;
  logic [D_W-1:0] fd_sin;
  logic [D_W-1:0] fd_cos;
  logic [8:0]     run_idx;
  logic           cycle_done;
  logic           busy;
  logic           err;

  modport master (
    input  enable, lane0_rq, lane1_rq, fd_ready, fd_sin, fd_cos,
    output lane0_sin, lane0_cos, lane1_sin, lane1_cos, lane0_vld, lane1_vld,
    output fd_rq, run_idx, cycle_done, busy, err
  );

  modport slave (
    output enable, lane0_rq, lane1_rq, fd_ready, fd_sin, fd_cos,
    input  lane0_sin, lane0_cos, lane1_sin, lane1_cos, lane0_vld, lane1_vld,
    input  fd_rq, run_idx, cycle_done, busy, err
  );
endinterface

// File: rtl/goertz_coeff_arbiter.sv
// Round-robin arbiter that lets two DSP lanes share one coefficient feeder.
// Each grant: ISSUE (fd_rq pulse) -> WAIT (for fd_ready) -> CAPT (CAPT_DLY cycles, latch on
// the last) -> DELIVER (lane vld pulse, pointer toggles, run_idx advances) -> GAP -> IDLE.
// Ports:
//   sys_clk    : sole clock, rising edge
//   sys_rst_n  : synchronous active-low reset
//   bus        : goertz_coeff_arbiter_if.master (lane requests/coefficients, feeder handshake,
//                run_idx, cycle_done, busy, err)
// Build option: define COEFF_TIMEOUT_EN to abort a WAIT after TO_CYC cycles without fd_ready and
// set the sticky err flag; otherwise WAIT is unbounded and err is tied low.
module goertz_coeff_arbiter #(
  parameter int unsigned D_W      = 16,
  parameter int unsigned NUM_RUNS = 8,
  parameter int unsigned CAPT_DLY = 2,
  parameter int unsigned TO_CYC   = 15
) (
  input logic                    sys_clk,
  input logic                    sys_rst_n,
  goertz_coeff_arbiter_if.master bus
);

  localparam logic [2:0] CaptLast = 3'(CAPT_DLY - 1);
  localparam logic [8:0] RunLast  = 9'(NUM_RUNS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapt,
    StDeliver,
    StGap
  } state_e;

  state_e         state_q, state_d;
  logic           grant_q, grant_d;  // lane being served: 0 = lane0, 1 = lane1
  logic           ptr_q, ptr_d;      // round-robin preference when both lanes request
  logic [8:0]     run_idx_q, run_idx_d;
  logic [2:0]     capt_cnt_q, capt_cnt_d;
  logic [D_W-1:0] lane0_sin_q, lane0_sin_d, lane0_cos_q, lane0_cos_d;
  logic [D_W-1:0] lane1_sin_q, lane1_sin_d, lane1_cos_q, lane1_cos_d;
  logic           fd_rq, lane0_vld, lane1_vld, cycle_done;

`ifdef COEFF_TIMEOUT_EN
  localparam logic [7:0] ToLast = 8'(TO_CYC - 1);
  logic       err_q, err_d;
  logic [7:0] to_cnt_q, to_cnt_d;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      ptr_q       <= 1'b0;
      run_idx_q   <= '0;
      capt_cnt_q  <= '0;
      lane0_sin_q <= '0;
      lane0_cos_q <= '0;
      lane1_sin_q <= '0;
      lane1_cos_q <= '0;
`ifdef COEFF_TIMEOUT_EN
      err_q       <= 1'b0;
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      run_idx_q   <= run_idx_d;
      capt_cnt_q  <= capt_cnt_d;
      lane0_sin_q <= lane0_sin_d;
      lane0_cos_q <= lane0_cos_d;
      lane1_sin_q <= lane1_sin_d;
      lane1_cos_q <= lane1_cos_d;
`ifdef COEFF_TIMEOUT_EN
      err_q       <= err_d;
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    run_idx_d   = run_idx_q;
    capt_cnt_d  = '0;
    lane0_sin_d = lane0_sin_q;
    lane0_cos_d = lane0_cos_q;
    lane1_sin_d = lane1_sin_q;
    lane1_cos_d = lane1_cos_q;
    fd_rq       = 1'b0;
    lane0_vld   = 1'b0;
    lane1_vld   = 1'b0;
    cycle_done  = 1'b0;
`ifdef COEFF_TIMEOUT_EN
    err_d       = err_q;
    to_cnt_d    = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.enable && (bus.lane0_rq || bus.lane1_rq)) begin
          // Pointer only matters on a tie; a lone requester always wins.
          grant_d = (bus.lane0_rq && bus.lane1_rq) ? ptr_q : bus.lane1_rq;
          state_d = StIssue;
        end
      end
      StIssue: begin
        fd_rq   = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (bus.fd_ready) begin
          state_d = StCapt;
`ifdef COEFF_TIMEOUT_EN
        end else if (to_cnt_q == ToLast) begin
          // Abandon the grant; pointer and run_idx stay as they were.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
`endif
        end
      end
      StCapt: begin
        if (capt_cnt_q == CaptLast) begin
          if (grant_q) begin
            lane1_sin_d = bus.fd_sin;
            lane1_cos_d = bus.fd_cos;
          end else begin
            lane0_sin_d = bus.fd_sin;
            lane0_cos_d = bus.fd_cos;
          end
          state_d = StDeliver;
        end else begin
          capt_cnt_d = capt_cnt_q + 3'd1;
        end
      end
      StDeliver: begin
        lane0_vld  = ~grant_q;
        lane1_vld  = grant_q;
        ptr_d      = ~ptr_q;
        cycle_done = (run_idx_q == RunLast);
        run_idx_d  = (run_idx_q == RunLast) ? 9'd0 : run_idx_q + 9'd1;
        state_d    = StGap;
      end
      StGap: begin
        // Requests are not looked at here: one dead cycle for feeder turnaround.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.lane0_sin  = lane0_sin_q;
  assign bus.lane0_cos  = lane0_cos_q;
  assign bus.lane1_sin  = lane1_sin_q;
  assign bus.lane1_cos  = lane1_cos_q;
  assign bus.lane0_vld  = lane0_vld;
  assign bus.lane1_vld  = lane1_vld;
  assign bus.fd_rq      = fd_rq;
  assign bus.run_idx    = run_idx_q;
  assign bus.cycle_done = cycle_done;
  assign bus.busy       = (state_q != StIdle);
`ifdef COEFF_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule
